// File: rtl/maf_decimate_buffer.sv
//------------------------------------------------------------------------------
// maf_decimate_buffer
//
// Sits after the 8-tap recursive moving-average filter. It takes the
// filter's 16-bit signed sample stream and does four things:
//   1. Discards the filter warm-up samples. This only happens when the
//      MAF_DECIM_WARMUP_EN macro is defined.
//   2. Keeps every DECIM-th remaining sample.
//   3. Buffers the kept samples in a first-word-fall-through FIFO of DEPTH
//      entries.
//   4. Presents the FIFO head to a consumer over a valid/ready handshake.
// A kept sample that finds the FIFO full, with no pop in the same cycle, is
// dropped. The drop sets a sticky overflow flag.
//
// Build option:
//   MAF_DECIM_WARMUP_EN  defined   : the first WARMUP in_valid samples after
//                                    reset are discarded. They do not advance
//                                    the decimation phase.
//                        undefined : no warm-up counter exists and WARMUP is
//                                    ignored.
//
// Parameters:
//   DECIM   decimation factor, 1..256 (1 keeps every sample)
//   DEPTH   FIFO depth, a power of 2, at least 2
//   WARMUP  number of leading samples discarded after reset
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset; clears all state
//   in_valid   in_data carries a new filter sample (no upstream backpressure)
//   in_data    signed filter sample
//   out_valid  out_data holds the FIFO head (registered, = level != 0)
//   out_ready  consumer takes the head this cycle
//   out_data   FIFO head sample (registered, stable while stalled)
//   level      FIFO occupancy 0..DEPTH (registered)
//   ovf        sticky overflow; set wins over ovf_clr
//   ovf_clr    clears ovf on the next edge
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module maf_decimate_buffer #(
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic signed [15:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [15:0]       out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);

  // Storage and pointers; the pointers wrap naturally modulo DEPTH
  logic signed [15:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PH_W-1:0]    phase_r;

  // Registered copies of the outputs
  logic               out_valid_r;
  logic signed [15:0] out_data_r;
  logic [LVL_W-1:0]   level_r;
  logic               ovf_r;

  // Per-cycle events and next-state values
  logic               accept_s;
  logic               keep_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic [LVL_W-1:0]   level_nxt_s;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic signed [15:0] head_nxt_s;
  logic               head_bypass_s;

`ifdef MAF_DECIM_WARMUP_EN
  // The warm-up counter saturates at WARMUP. Once it is done it stays done
  // until the next reset.
  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WU_W-1:0] WU_DONE = WU_W'(WARMUP);

  logic [WU_W-1:0] warm_cnt_r;
  logic            warm_done_s;

  assign warm_done_s = (warm_cnt_r == WU_DONE);

  // Warm-up counter: counts in_valid samples until WARMUP have been discarded
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      warm_cnt_r <= '0;
    end else if (in_valid && !warm_done_s) begin
      warm_cnt_r <= warm_cnt_r + WU_W'(1);
    end else begin
      warm_cnt_r <= warm_cnt_r;
    end
  end

  assign accept_s = in_valid && warm_done_s;
`else
  assign accept_s = in_valid;
`endif

  // A sample is kept on the last phase of each DECIM-long group
  assign keep_s = accept_s && (phase_r == PH_LAST);

  // A pop needs a valid head, so push and pop on an empty FIFO cannot occur
  assign pop_s  = out_valid_r && out_ready;

  // A full FIFO still takes the sample if the head leaves in the same cycle
  assign push_s = keep_s && ((level_r != LVL_FULL) || pop_s);
  assign drop_s = keep_s && !push_s;

  // The incoming sample becomes the head directly when nothing else remains
  // in front of it (an empty FIFO, or one entry that is popping now)
  assign head_bypass_s = push_s && (level_r == {{(LVL_W-1){1'b0}}, pop_s});

  // Next occupancy, read pointer and head value for the registered outputs
  always_comb begin
    level_nxt_s  = level_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = out_data_r;

    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    // When the FIFO goes empty, the last head value is held. out_valid=0
    // marks it as meaningless.
    if (level_nxt_s == '0) begin
      head_nxt_s = out_data_r;
    end else if (head_bypass_s) begin
      head_nxt_s = in_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage: write the pushed sample at the write pointer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'sd0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer, occupancy and head registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'sd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      level_r     <= level_nxt_s;
      out_valid_r <= (level_nxt_s != '0);
      out_data_r  <= head_nxt_s;
    end
  end

  // Decimation phase: advances on every accepted sample, including dropped
  // ones, and holds while in_valid is low
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_r <= '0;
    end else if (accept_s) begin
      if (phase_r == PH_LAST) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PH_W'(1);
      end
    end else begin
      phase_r <= phase_r;
    end
  end

  // Sticky overflow: a drop in the same cycle wins over a clear request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign level     = level_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_maf_decimate_buffer.sv
//------------------------------------------------------------------------------
// Bench for maf_decimate_buffer. Three instances (DECIM = 4, 3, 1) share one
// stimulus stream. Each instance has its own behavioural model. The model
// counts post-warm-up samples and keeps those whose count is a multiple of
// DECIM. Kept samples go into a plain list that shifts on pop.
// Directed phases pin specific values. A random phase follows.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_maf_decimate_buffer;

  localparam int DEPTH = 8;
`ifdef MAF_DECIM_WARMUP_EN
  localparam int WARM = 8;
`else
  localparam int WARM = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;
  logic               ovf_clr;

  logic               ov [3];
  logic signed [15:0] od [3];
  logic [3:0]         lv [3];
  logic               of [3];

  maf_decimate_buffer #(.DECIM(4), .DEPTH(DEPTH), .WARMUP(8)) u_d4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .level(lv[0]), .ovf(of[0]), .ovf_clr(ovf_clr));

  maf_decimate_buffer #(.DECIM(3), .DEPTH(DEPTH), .WARMUP(8)) u_d3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .level(lv[1]), .ovf(of[1]), .ovf_clr(ovf_clr));

  maf_decimate_buffer #(.DECIM(1), .DEPTH(DEPTH), .WARMUP(8)) u_d1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .level(lv[2]), .ovf(of[2]), .ovf_clr(ovf_clr));

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_list(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", name, i), got[i], exp[i]);
  endtask

  // ---------------- behavioural model ----------------
  int                 mdec [3] = '{4, 3, 1};
  int                 mcnt [3];
  int                 mn   [3];
  int                 mw   [3];
  bit                 movf [3];
  logic signed [15:0] mlist [3][DEPTH];
  bit                 started = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) started = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (!reset_n) begin
          mcnt[k] = 0; mn[k] = 0; mw[k] = 0; movf[k] = 1'b0;
        end else begin
          bit pop, keep, drop;
          pop  = (mcnt[k] > 0) && out_ready;
          keep = 1'b0;
          drop = 1'b0;
          if (in_valid) begin
            if (mw[k] < WARM) mw[k]++;
            else begin
              mn[k]++;
              keep = (mn[k] % mdec[k]) == 0;
            end
          end
          if (pop) begin
            for (int j = 0; j < DEPTH - 1; j++) mlist[k][j] = mlist[k][j+1];
            mcnt[k]--;
          end
          if (keep) begin
            if (mcnt[k] < DEPTH) begin
              mlist[k][mcnt[k]] = in_data;
              mcnt[k]++;
            end else drop = 1'b1;
          end
          if (drop) movf[k] = 1'b1;
          else if (ovf_clr) movf[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- compare + output logging ----------------
  bit log_en = 1'b0;
  int log0[$], log1[$], log2[$];

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("d%0d_valid", k), ov[k], (mcnt[k] != 0) ? 1 : 0);
          chk($sformatf("d%0d_level", k), lv[k], mcnt[k]);
          chk($sformatf("d%0d_ovf", k), of[k], movf[k]);
          if (mcnt[k] != 0) chk($sformatf("d%0d_data", k), od[k], mlist[k][0]);
        end
        if (log_en && out_ready) begin
          if (ov[0]) log0.push_back(od[0]);
          if (ov[1]) log1.push_back(od[1]);
          if (ov[2]) log2.push_back(od[2]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int d, input bit r, input bit c, input bit rn);
    in_valid  = v;
    in_data   = 16'(d);
    out_ready = r;
    ovf_clr   = c;
    reset_n   = rn;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_q[$];
    int rp;

    drive(0, 0, 0, 0, 0);

    // Reset held for three cycles, then idle: everything stays zero
    for (int c = 0; c < 5; c++) begin
      if (c == 3) drive(0, 0, 0, 0, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("idle_valid%0d", k), ov[k], 0);
        chk($sformatf("idle_data%0d", k), od[k], 0);
        chk($sformatf("idle_level%0d", k), lv[k], 0);
        chk($sformatf("idle_ovf%0d", k), of[k], 0);
      end
    end

    // Warm-up plus decimation on the DECIM=4 instance, samples 1..24
    log0.delete();
    log_en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      drive(1, i, 1, 0, 1);
      tick();
      if (i == WARM + 4) begin
        chk("first_keep_valid", ov[0], 1);
        chk("first_keep_data", od[0], WARM + 4);
      end
    end
    drive(0, 0, 1, 0, 1);
    repeat (4) tick();
    log_en = 1'b0;
`ifdef MAF_DECIM_WARMUP_EN
    exp_q = '{12, 16, 20, 24};
`else
    exp_q = '{4, 8, 12, 16, 20, 24};
`endif
    chk_list("decim4", log0, exp_q);

    // Gapped input on the DECIM=3 instance from a fresh reset
    drive(0, 0, 1, 0, 0);
    tick();
    for (int i = 0; i < WARM; i++) begin
      drive(1, 0, 1, 0, 1);
      tick();
    end
    log1.delete();
    log_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 100 + i, 1, 0, 1);
      tick();
      drive(0, 0, 1, 0, 1);
      tick();
    end
    repeat (3) tick();
    log_en = 1'b0;
    exp_q = '{102, 105};
    chk_list("gapped3", log1, exp_q);

    // Overflow on the DECIM=1 instance: ten samples -5..4 with no consumer
    for (int i = 0; i < 10; i++) begin
      drive(1, i - 5, 0, 0, 1);
      tick();
      if (i == 7) begin
        chk("ovf_level_at8", lv[2], 8);
        chk("ovf_flag_at8", of[2], 0);
      end
      if (i == 8) begin
        chk("ovf_level_at9", lv[2], 8);
        chk("ovf_flag_at9", of[2], 1);
      end
    end
    log2.delete();
    log_en = 1'b1;
    drive(0, 0, 1, 0, 1);
    repeat (8) tick();
    log_en = 1'b0;
    chk("drain_level", lv[2], 0);
    exp_q = '{-5, -4, -3, -2, -1, 0, 1, 2};
    chk_list("ovf_drain", log2, exp_q);

    // Refill, then a clear request together with a new drop: the flag stays set
    for (int i = 0; i < 8; i++) begin
      drive(1, 50 + i, 0, 0, 1);
      tick();
    end
    chk("refill_level", lv[2], 8);
    drive(1, 99, 0, 1, 1);
    tick();
    chk("clr_with_drop", of[2], 1);
    drive(0, 0, 0, 1, 1);
    tick();
    chk("clr_alone", of[2], 0);

    // Full FIFO with a push and a pop in the same cycle
    drive(1, 32767, 1, 0, 1);
    tick();
    chk("full_pushpop_level", lv[2], 8);
    chk("full_pushpop_ovf", of[2], 0);
    log2.delete();
    log_en = 1'b1;
    drive(0, 0, 1, 0, 1);
    repeat (8) tick();
    log_en = 1'b0;
    exp_q = '{51, 52, 53, 54, 55, 56, 57, 32767};
    chk_list("full_drain", log2, exp_q);
    if (log2.size() > 0) chk("last_is_7fff", log2[log2.size() - 1], 32767);

    // Reset in the middle of operation with five entries buffered
    for (int i = 0; i < 5; i++) begin
      drive(1, 200 + i, 0, 0, 1);
      tick();
    end
    chk("pre_reset_level", lv[2], 5);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("mid_reset_level", lv[2], 0);
    chk("mid_reset_valid", ov[2], 0);
    for (int i = 0; i < WARM; i++) begin
      drive(1, 300 + i, 0, 0, 1);
      tick();
      chk("warm_restart_drop", lv[2], 0);
    end
    drive(1, 400, 0, 0, 1);
    tick();
    chk("post_warm_level", lv[2], 1);
    chk("post_warm_data", od[2], 400);

    // Random traffic with varying consumer pressure, clears and rare resets
    for (int b = 0; b < 8; b++) begin
      case (b % 4)
        0: rp = 100;
        1: rp = 50;
        2: rp = 10;
        default: rp = 80;
      endcase
      repeat (500) begin
        drive($urandom_range(0, 99) < 70, int'($urandom), $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 4, !($urandom_range(0, 999) < 4));
        tick();
      end
    end

    drive(0, 0, 0, 0, 1);
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
